// File: rtl/ram_dp_pkg.sv
// ram_dp_pkg: shared definitions for the Hack dual-port data memory.
//   state_e      - sweep FSM states (ST_CLEAR, ST_RUN)
//   HACK_DATA_W  - default word width of the Hack platform
//   HACK_ADDR_W  - default address width of the Hack platform
//   SCREEN_BASE  - first screen word, used by port B clients
//   idx_w()      - array index width for a given depth (minimum 1)
package ram_dp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int HACK_DATA_W = 16;
  localparam int HACK_ADDR_W = 15;
  localparam int SCREEN_BASE = 16384;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_dp_if.sv
// ram_dp_if: request/response bundle of the dual-port data memory.
//   ready_o              - memory is out of its clear sweep and accepts requests
//   a_en_i / a_we_i      - port A strobe and write select
//   a_addr_i / a_wdata_i - port A address and write data
//   a_rdata_o / a_rvalid_o - port A read data and one-cycle valid pulse
//   b_en_i / b_addr_i    - port B read strobe and address
//   b_rdata_o / b_rvalid_o - port B read data and one-cycle valid pulse
// Modports: master = CPU / scanner side, slave = memory side.
interface ram_dp_if
  import ram_dp_pkg::*;
#(
  parameter int DATA_W = HACK_DATA_W,
  parameter int ADDR_W = HACK_ADDR_W
) ();

  logic              ready_o;
  logic              a_en_i;
  logic              a_we_i;
  logic [ADDR_W-1:0] a_addr_i;
  logic [DATA_W-1:0] a_wdata_i;
  logic [DATA_W-1:0] a_rdata_o;
  logic              a_rvalid_o;
  logic              b_en_i;
  logic [ADDR_W-1:0] b_addr_i;
  logic [DATA_W-1:0] b_rdata_o;
  logic              b_rvalid_o;

  modport master (
    input  ready_o, a_rdata_o, a_rvalid_o, b_rdata_o, b_rvalid_o,
    output a_en_i, a_we_i, a_addr_i, a_wdata_i, b_en_i, b_addr_i
  );

  modport slave (
    output ready_o, a_rdata_o, a_rvalid_o, b_rdata_o, b_rvalid_o,
    input  a_en_i, a_we_i, a_addr_i, a_wdata_i, b_en_i, b_addr_i
  );

endinterface

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: post-reset zero-fill sweep for ram_dp.
//   clk_i      - clock, rising edge
//   reset_i    - synchronous, active-low reset (restarts the sweep at 0)
//   clr_we_o   - write enable of the clear path (high during ST_CLEAR)
//   clr_addr_o - word being cleared this cycle
//   ready_o    - high in ST_RUN
// One word is cleared per cycle; the cycle that clears DEPTH-1 moves to
// ST_RUN, so ready_o rises exactly DEPTH edges after reset release.
module ram_dp_clr
  import ram_dp_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  output logic                      clr_we_o,
  output logic [idx_w(DEPTH)-1:0]   clr_addr_o,
  output logic                      ready_o
);

  localparam int                 IDX_W = idx_w(DEPTH);
  localparam logic [IDX_W-1:0]   LAST  = IDX_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_we_o = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we_o = 1'b1;
        if (ptr_q == LAST) begin
          state_d = ST_RUN;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign clr_addr_o = ptr_q;
  assign ready_o    = (state_q == ST_RUN);

endmodule

// File: rtl/ram_dp.sv
// ram_dp: parametrised dual-port data memory for the Hack platform.
//   clk_i   - clock, rising edge
//   reset_i - synchronous, active-low reset; starts a zero-fill sweep
//   bus     - ram_dp_if.slave: port A read/write (CPU), port B read-only
//             (screen/peripheral scanner), ready_o, registered read data
//             with one-cycle rvalid pulses.
// Reads have one cycle of latency. Out-of-range addresses drop writes and
// read back zero (rvalid still pulses).
// Build option: define RAM_DP_FWD_EN to forward port A write data to a
// port B read of the same address in the same cycle (write-first); left
// undefined, port B sees the pre-write word (read-first).
module ram_dp
  import ram_dp_pkg::*;
#(
  parameter int DATA_W = HACK_DATA_W,
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic     clk_i,
  input  logic     reset_i,
  ram_dp_if.slave  bus
);

  localparam int                IDX_W   = idx_w(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [IDX_W-1:0]  clr_idx;
  logic              ready;

  ram_dp_clr #(
    .DEPTH (DEPTH)
  ) u_clr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_idx),
    .ready_o    (ready)
  );

  // Request decode (p0): requests only count in ST_RUN and outside reset.
  logic              run;
  logic              a_in, b_in;
  logic [IDX_W-1:0]  a_idx, b_idx;
  logic              a_wr, a_rd, b_rd;

  assign run   = ready & reset_i;
  assign a_in  = {1'b0, bus.a_addr_i} < DEPTH_L;
  assign b_in  = {1'b0, bus.b_addr_i} < DEPTH_L;
  assign a_idx = bus.a_addr_i[IDX_W-1:0];
  assign b_idx = bus.b_addr_i[IDX_W-1:0];
  assign a_wr  = run & bus.a_en_i & bus.a_we_i & a_in;
  assign a_rd  = run & bus.a_en_i & ~bus.a_we_i;
  assign b_rd  = run & bus.b_en_i;

  // The clear sweep borrows port A's write path; the two never overlap
  // because a_wr requires ST_RUN.
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  assign wr_en   = clr_we | a_wr;
  assign wr_idx  = clr_we ? clr_idx : a_idx;
  assign wr_data = clr_we ? '0 : bus.a_wdata_i;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  logic [DATA_W-1:0] b_word;

`ifdef RAM_DP_FWD_EN
  logic fwd_hit;
  assign fwd_hit = a_wr & b_in & (bus.a_addr_i == bus.b_addr_i);
  assign b_word  = fwd_hit ? bus.a_wdata_i : mem[b_idx];
`else
  assign b_word  = mem[b_idx];
`endif

  // Read register stage (p1): rdata holds between reads, rvalid pulses.
  logic [DATA_W-1:0] a_rdata_p1, b_rdata_p1;
  logic              a_vld_p1, b_vld_p1;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      a_rdata_p1 <= '0;
      b_rdata_p1 <= '0;
      a_vld_p1   <= 1'b0;
      b_vld_p1   <= 1'b0;
    end else begin
      a_vld_p1 <= a_rd;
      b_vld_p1 <= b_rd;
      if (a_rd) begin
        a_rdata_p1 <= a_in ? mem[a_idx] : '0;
      end
      if (b_rd) begin
        b_rdata_p1 <= b_in ? b_word : '0;
      end
    end
  end

  assign bus.ready_o    = ready;
  assign bus.a_rdata_o  = a_rdata_p1;
  assign bus.a_rvalid_o = a_vld_p1;
  assign bus.b_rdata_o  = b_rdata_p1;
  assign bus.b_rvalid_o = b_vld_p1;

endmodule

// File: tb/tb_ram_dp.sv
// tb_ram_dp: directed bench for ram_dp with DEPTH=16, ADDR_W=5, DATA_W=16.
// Covers reset/sweep timing, read/write, same-cycle collision (both build
// options), out-of-range addresses, continuous port B reads and mid-run reset.
module tb_ram_dp;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int DP = 16;

`ifdef RAM_DP_FWD_EN
  localparam logic [DW-1:0] COL_EXP = 16'hBEEF;
`else
  localparam logic [DW-1:0] COL_EXP = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic          a_en;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          b_en;
    logic [AW-1:0] b_addr;
    logic          exp_arv;
    logic [DW-1:0] exp_ard;
    logic          exp_brv;
    logic [DW-1:0] exp_brd;
  } vec_t;

  vec_t          vecs [12];
  logic [DW-1:0] exp_mem [DP];

  function automatic vec_t mk(input logic ae, input logic aw, input logic [AW-1:0] aa,
                              input logic [DW-1:0] wd, input logic be, input logic [AW-1:0] ba,
                              input logic arv, input logic [DW-1:0] ard,
                              input logic brv, input logic [DW-1:0] brd);
    vec_t v;
    v.a_en = ae; v.a_we = aw; v.a_addr = aa; v.a_wdata = wd;
    v.b_en = be; v.b_addr = ba;
    v.exp_arv = arv; v.exp_ard = ard; v.exp_brv = brv; v.exp_brd = brd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ae, input logic aw, input logic [AW-1:0] aa,
                       input logic [DW-1:0] wd, input logic be, input logic [AW-1:0] ba);
    bus.a_en_i    = ae;
    bus.a_we_i    = aw;
    bus.a_addr_i  = aa;
    bus.a_wdata_i = wd;
    bus.b_en_i    = be;
    bus.b_addr_i  = ba;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1, 1, 5'd5,  16'h1234, 0, 5'd0,  0, 16'h0000, 0, 16'h0000);
    vecs[1]  = mk(1, 0, 5'd5,  16'h0000, 1, 5'd5,  1, 16'h1234, 1, 16'h1234);
    vecs[2]  = mk(0, 0, 5'd0,  16'h0000, 0, 5'd0,  0, 16'h1234, 0, 16'h1234);
    vecs[3]  = mk(1, 1, 5'd3,  16'hBEEF, 1, 5'd3,  0, 16'h1234, 1, COL_EXP);
    vecs[4]  = mk(1, 0, 5'd3,  16'h0000, 1, 5'd3,  1, 16'hBEEF, 1, 16'hBEEF);
    vecs[5]  = mk(1, 1, 5'd20, 16'hAAAA, 1, 5'd4,  0, 16'hBEEF, 1, 16'h0000);
    vecs[6]  = mk(1, 0, 5'd4,  16'h0000, 1, 5'd20, 1, 16'h0000, 1, 16'h0000);
    vecs[7]  = mk(1, 0, 5'd20, 16'h0000, 0, 5'd0,  1, 16'h0000, 0, 16'h0000);
    vecs[8]  = mk(0, 1, 5'd0,  16'h7777, 1, 5'd0,  0, 16'h0000, 1, 16'h0000);
    vecs[9]  = mk(1, 0, 5'd0,  16'h0000, 1, 5'd5,  1, 16'h0000, 1, 16'h1234);
    vecs[10] = mk(1, 1, 5'd7,  16'h00FF, 1, 5'd6,  0, 16'h0000, 1, 16'h0000);
    vecs[11] = mk(1, 0, 5'd7,  16'h0000, 1, 5'd7,  1, 16'h00FF, 1, 16'h00FF);

    // Reset state
    rst_n = 1'b0;
    drive(0, 0, '0, '0, 0, '0);
    repeat (3) step();
    chk("rst_ready",  32'(bus.ready_o),    32'd0);
    chk("rst_arv",    32'(bus.a_rvalid_o), 32'd0);
    chk("rst_brv",    32'(bus.b_rvalid_o), 32'd0);
    chk("rst_ard",    32'(bus.a_rdata_o),  32'd0);
    chk("rst_brd",    32'(bus.b_rdata_o),  32'd0);

    // Sweep: requests ignored, ready rises after exactly DP edges
    rst_n = 1'b1;
    drive(1, 0, 5'd0, '0, 1, 5'd0);
    for (int k = 1; k <= DP; k++) begin
      step();
      chk($sformatf("sweep_ready[%0d]", k), 32'(bus.ready_o), (k == DP) ? 32'd1 : 32'd0);
      chk($sformatf("sweep_arv[%0d]", k), 32'(bus.a_rvalid_o), 32'd0);
      chk($sformatf("sweep_brv[%0d]", k), 32'(bus.b_rvalid_o), 32'd0);
    end

    // Both ports read every cycle: all zero, one rvalid per read
    for (int i = 0; i < DP; i++) begin
      drive(1, 0, AW'(i), '0, 1, AW'(DP - 1 - i));
      step();
      chk($sformatf("clr_arv[%0d]", i), 32'(bus.a_rvalid_o), 32'd1);
      chk($sformatf("clr_ard[%0d]", i), 32'(bus.a_rdata_o),  32'd0);
      chk($sformatf("clr_brv[%0d]", i), 32'(bus.b_rvalid_o), 32'd1);
      chk($sformatf("clr_brd[%0d]", i), 32'(bus.b_rdata_o),  32'd0);
    end

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].a_en, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wdata,
            vecs[i].b_en, vecs[i].b_addr);
      step();
      chk($sformatf("vec%0d_arv", i), 32'(bus.a_rvalid_o), 32'(vecs[i].exp_arv));
      chk($sformatf("vec%0d_ard", i), 32'(bus.a_rdata_o),  32'(vecs[i].exp_ard));
      chk($sformatf("vec%0d_brv", i), 32'(bus.b_rvalid_o), 32'(vecs[i].exp_brv));
      chk($sformatf("vec%0d_brd", i), 32'(bus.b_rdata_o),  32'(vecs[i].exp_brd));
    end

    // Continuous port B scan while port A writes 0xFFFF to addr 15
    for (int i = 0; i < DP; i++) exp_mem[i] = '0;
    exp_mem[3] = 16'hBEEF;
    exp_mem[5] = 16'h1234;
    exp_mem[7] = 16'h00FF;
    for (int i = 0; i < DP; i++) begin
      if (i == 10) drive(1, 1, 5'd15, 16'hFFFF, 1, AW'(i));
      else         drive(0, 0, 5'd0, 16'h0000, 1, AW'(i));
      step();
      chk($sformatf("scan_brv[%0d]", i), 32'(bus.b_rvalid_o), 32'd1);
      chk($sformatf("scan_brd[%0d]", i), 32'(bus.b_rdata_o),  32'(exp_mem[i]));
      chk($sformatf("scan_arv[%0d]", i), 32'(bus.a_rvalid_o), 32'd0);
      if (i == 10) exp_mem[15] = 16'hFFFF;
    end

    // Fill with nonzero data, spot-check, then reset mid-run with reads pending
    for (int i = 0; i < DP; i++) begin
      drive(1, 1, AW'(i), 16'hA500 | 16'(i), 0, 5'd0);
      step();
    end
    drive(1, 0, 5'd9, '0, 1, 5'd14);
    step();
    chk("fill_ard", 32'(bus.a_rdata_o), 32'h0000A509);
    chk("fill_brd", 32'(bus.b_rdata_o), 32'h0000A50E);

    drive(1, 0, 5'd1, '0, 1, 5'd2);
    rst_n = 1'b0;
    step();
    chk("mrst_ready", 32'(bus.ready_o),    32'd0);
    chk("mrst_arv",   32'(bus.a_rvalid_o), 32'd0);
    chk("mrst_brv",   32'(bus.b_rvalid_o), 32'd0);
    chk("mrst_ard",   32'(bus.a_rdata_o),  32'd0);
    chk("mrst_brd",   32'(bus.b_rdata_o),  32'd0);

    rst_n = 1'b1;
    drive(0, 0, '0, '0, 0, '0);
    for (int k = 1; k <= DP; k++) begin
      step();
      chk($sformatf("resweep_ready[%0d]", k), 32'(bus.ready_o), (k == DP) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < DP; i++) begin
      drive(1, 0, AW'(i), '0, 1, AW'((i + 8) % DP));
      step();
      chk($sformatf("post_arv[%0d]", i), 32'(bus.a_rvalid_o), 32'd1);
      chk($sformatf("post_ard[%0d]", i), 32'(bus.a_rdata_o),  32'd0);
      chk($sformatf("post_brv[%0d]", i), 32'(bus.b_rvalid_o), 32'd1);
      chk($sformatf("post_brd[%0d]", i), 32'(bus.b_rdata_o),  32'd0);
    end
    drive(0, 0, '0, '0, 0, '0);
    step();
    chk("idle_arv", 32'(bus.a_rvalid_o), 32'd0);
    chk("idle_brv", 32'(bus.b_rvalid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_dp.md
# ram_dp

Parametrised dual-port data memory for the Hack platform, succeeding the single-port 32K x 16 RAM. Port A serves CPU loads/stores; port B is a read-only port for the screen/peripheral scanner. Both reads are registered (1-cycle latency). After reset a sweep FSM zero-fills the array, so memory contents are deterministic and cleared rather than held at X.

## Interface
- DATA_W, 16, word width in bits
- ADDR_W, 15, address width
- DEPTH, 1<<ADDR_W, number of words; must be ≤ 2^ADDR_W
- clk_i  in  1  single clock, rising edge
- reset_i  in  1  synchronous, active-low reset
- ready_o  out  1  high when in RUN; requests accepted only while high
- a_en_i  in  1  port A request strobe
- a_we_i  in  1  port A write (1) / read (0), qualified by a_en_i
- a_addr_i  in  ADDR_W  port A address
- a_wdata_i  in  DATA_W  port A write data
- a_rdata_o  out  DATA_W  port A read data
- a_rvalid_o  out  1  one-cycle pulse: a_rdata_o updated this cycle
- b_en_i  in  1  port B read strobe
- b_addr_i  in  ADDR_W  port B address
- b_rdata_o  out  DATA_W  port B read data
- b_rvalid_o  out  1  one-cycle pulse: b_rdata_o updated this cycle

## Operation
- FSM states: CLEAR, RUN.
- reset_i low at a clock edge: state←CLEAR, clear pointer←0. ready_o, a_rvalid_o and b_rvalid_o go to 0. a_rdata_o and b_rdata_o go to 0.
- CLEAR: one word per cycle, mem[ptr]←0, ptr++. When ptr==DEPTH-1 is written, go to RUN next cycle. ready_o stays 0. Port inputs are ignored: no writes, no rvalid.
- RUN: ready_o=1.
  - Port A with a_en_i & a_we_i: mem[a_addr_i]←a_wdata_i at the edge. No rvalid.
  - Port A with a_en_i & !a_we_i: a_rdata_o←mem[a_addr_i] at the edge, and a_rvalid_o=1 for that cycle.
  - Port B with b_en_i: same as a port A read, on b_rdata_o / b_rvalid_o.
- rdata outputs hold their value between reads. rvalid outputs are 0 in every cycle without a completed read.
- Out-of-range address (addr ≥ DEPTH): the write is dropped; the read returns 0 and still pulses rvalid.
- Collision (port A write and port B read of the same address in the same cycle): port B returns the old word unless RAM_DP_FWD_EN is defined.
- Reset asserted mid-CLEAR or mid-RUN: the sweep restarts from 0. Any in-flight rvalid is suppressed, since the outputs are cleared on that edge.

## Timing
- Read latency is 1 cycle: address presented at edge N, data and rvalid visible after edge N+1.
- Write is visible to a read issued on the following cycle (edge N+1).
- Reset release to ready_o=1 is exactly DEPTH cycles. ready_o first reads 1 after edge DEPTH following the first edge with reset_i high.
- Back-to-back reads every cycle on both ports give sustained throughput of 1 word per port per cycle.

## Configuration
- RAM_DP_FWD_EN defined: on a port A write / port B read of the same in-range address in the same cycle, b_rdata_o returns a_wdata_i (write-first forwarding). This adds a comparator and a mux on port B.
- RAM_DP_FWD_EN undefined: port B returns the pre-write contents (read-first). The array maps to plain dual-port block RAM.

## Structure
- Shared package ram_dp_pkg holds:
  - the state enum (ST_CLEAR, ST_RUN);
  - default constants HACK_DATA_W=16 and HACK_ADDR_W=15;
  - the screen base address constant 16384 used by port B clients.
- One sub-module, ram_dp_clr: the sweep FSM and pointer. It outputs the clear write-enable, the clear address and ready_o.
- The top level muxes the clear path onto port A's write path and owns the array and the read registers.

## Test plan
- Reset then release with DEPTH=16: ready_o low for 16 cycles then high. Reads of addresses 0..15 all return 0x0000 with one rvalid pulse each.
- Write 0x1234 at A addr 5, then read A addr 5 on the next cycle: a_rdata_o=0x1234 one cycle after the read and a_rvalid_o pulses once.
- Same cycle, A writes 0xBEEF at addr 3 (old value 0x0000) and B reads addr 3: b_rdata_o=0x0000 without the macro and 0xBEEF with RAM_DP_FWD_EN.
- Continuous B reads of addresses 0..15 while A writes 0xFFFF to addr 15: b_rvalid_o high every cycle and data matches the model.
- Out-of-range with DEPTH=16, ADDR_W=5: write 0xAAAA at addr 20 has no effect on addrs 0..15, and a read of addr 20 returns 0x0000.
- Assert reset_i low mid-RUN after filling memory with nonzero data: ready_o and rvalid go to 0 next edge, then after 16 cycles every address reads 0x0000.
